score_display_sequencer: RTL and testbench
==========================================

Name: score_display_sequencer

Overview:
Game-level controller sitting between the score tracker and the 7-segment display driver. It sequences the game states idle, play, game-over hold and high-score show. On game over it latches the final score and shows it, flashing, for a fixed hold time before switching to the high score. It also gates snake movement through runEn and converts the selected score to two BCD digits.

Parameters:
TICK_DIV, 1000000, clk cycles per display tick (prescaler period)
HOLD_TICKS, 30, ticks the final score stays on display after game over
BLINK_TICKS, 5, ticks per blink half-period during hold
MAX_SCORE, 50, score at or above which the game ends as complete

Ports:
clk  input  1  system clock
nRst  input  1  asynchronous active-low reset
startBtn  input  1  single-cycle start pulse, already synchronized and edge-detected
badColl  input  1  single-cycle pulse: snake hit wall or self
goodColl  input  1  single-cycle pulse: food eaten (observed only for the simultaneity rule)
currScore  input  7  live score from score tracker
highScore  input  7  high score from score tracker
runEn  output  1  high only in PLAY; enables snake movement
gameState  output  2  encoded state: 0 IDLE, 1 PLAY, 2 HOLD, 3 HIGH
blank  output  1  1 = display dark (blink off phase)
tens  output  4  BCD tens digit of displayed value
ones  output  4  BCD ones digit of displayed value

Behaviour:
- Interface: reset nRst, asynchronous, active-low; clock clk.
- Reset values: state IDLE, runEn 0, blank 0, tens 0, ones 0, latched final score 0, prescaler 0, hold counter 0, blink counter 0.
- All outputs are registered. A display value change appears 1 cycle after the input or state change that causes it.
- Display source by state:
  - IDLE and HIGH show highScore.
  - PLAY shows currScore.
  - HOLD shows finalScore, the value latched on entry to HOLD.
- Transitions:
  - IDLE --startBtn--> PLAY.
  - PLAY --(badColl or currScore >= MAX_SCORE)--> HOLD. On that edge, finalScore <= currScore.
  - HOLD --hold counter reaches HOLD_TICKS--> HIGH.
  - HIGH --startBtn--> PLAY.
  - startBtn is ignored in PLAY and HOLD.
  - badColl is ignored outside PLAY.
- Simultaneous goodColl and badColl in PLAY: badColl wins. finalScore is the pre-increment currScore of that cycle.
- Prescaler:
  - Counts 0..TICK_DIV-1 only in HOLD and issues a tick on wrap.
  - Cleared on every entry to HOLD, so the first tick comes TICK_DIV cycles after entry.
- Hold counter: increments per tick. HOLD exits in the cycle the HOLDth tick occurs, so HOLD lasts HOLD_TICKS*TICK_DIV cycles.
- BCD conversion:
  - Values 0..99 map to tens = v/10, ones = v%10.
  - Values > 99 saturate to 9,9.
  - Conversion is purely combinational ahead of the output register.
- A reset mid-HOLD returns to IDLE and clears all counters. finalScore is lost.

Optional Feature:
SCORE_FLASH_EN:
- Defined: blank toggles every BLINK_TICKS ticks while in HOLD. The first half-period is visible (blank=0), and blank is forced to 0 on leaving HOLD.
- Undefined: blank is tied to 0, the blink counter is not built, and HOLD shows finalScore steadily.

Decomposition:
- Package snake_pkg holds:
  - the game_state_t enum (IDLE=2'd0, PLAY=2'd1, HOLD=2'd2, HIGH=2'd3)
  - SCORE_W=7
  - BCD_W=4
  - the MAX_SCORE default constant, shared with the score tracker
- One sub-module, bin2bcd7: combinational 7-bit to two-digit BCD with saturation. It is reused later by the length display.

Test Plan:
Use TICK_DIV=4, HOLD_TICKS=6, BLINK_TICKS=2 for all scenarios.
1. Reset then idle: highScore=12 -> 1 cycle after reset release, gameState=0, tens=1, ones=2, runEn=0; startBtn pulse -> next cycle gameState=1, runEn=1.
2. Play display: currScore steps 7, 8, 9 in PLAY -> tens/ones follow one cycle later (0/7, 0/8, 0/9), blank=0.
3. Collision: currScore=23, badColl pulse -> gameState=2, runEn=0, display 2/3. The tracker then drives currScore=0, highScore=30 and the display stays 2/3 for 24 cycles, then gameState=3 showing 3/0.
4. Max score: currScore reaches 50 without badColl -> HOLD entered next cycle, finalScore=50; startBtn during HOLD ignored (gameState stays 2).
5. Flash (SCORE_FLASH_EN defined): in HOLD, blank pattern is 0 for 8 cycles, 1 for 8, 0 for 8, then 0 in HIGH. Without the macro, blank stays 0 throughout.
6. Edge cases:
   - goodColl and badColl in the same cycle with currScore=9 -> finalScore=9.
   - highScore=127 in IDLE -> display 9/9.
   - nRst asserted mid-HOLD -> immediately gameState=0 and all outputs 0.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared types and constants for the snake game controllers.
package snake_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        HOLD = 2'd2,
        HIGH = 2'd3
    } game_state_t;

    localparam int SCORE_W           = 7;
    localparam int BCD_W             = 4;
    localparam int MAX_SCORE_DEFAULT = 50;

endpackage

// File: rtl/score_display_sequencer_bin2bcd7.sv
// 7-bit binary to two BCD digits; anything above 99 saturates to 9,9.
module bin2bcd7
    import snake_pkg::*;
(
    input  logic [SCORE_W-1:0] value,
    output logic [BCD_W-1:0]   tens,
    output logic [BCD_W-1:0]   ones
);

    int quot;

    always_comb begin
        quot = 0;
        tens = BCD_W'(9);
        ones = BCD_W'(9);
        if (int'(value) <= 99) begin
            quot = int'(value) / 10;
            tens = BCD_W'(quot);
            ones = BCD_W'(int'(value) - quot * 10);
        end
    end

endmodule

// File: rtl/score_display_sequencer.sv
// Game-level sequencer: IDLE/PLAY/HOLD/HIGH, final-score latch and BCD display.
// Optional blinking of the final score during HOLD is enabled with SCORE_FLASH_EN.
module score_display_sequencer
    import snake_pkg::*;
#(
    parameter int TICK_DIV    = 1000000,
    parameter int HOLD_TICKS  = 30,
    parameter int BLINK_TICKS = 5,
    parameter int MAX_SCORE   = MAX_SCORE_DEFAULT
)
(
    input  logic                clk,
    input  logic                nRst,
    input  logic                startBtn,
    input  logic                badColl,
    input  logic                goodColl,
    input  logic [SCORE_W-1:0]  currScore,
    input  logic [SCORE_W-1:0]  highScore,
    output logic                runEn,
    output logic [1:0]          gameState,
    output logic                blank,
    output logic [BCD_W-1:0]    tens,
    output logic [BCD_W-1:0]    ones
);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_PLAY = PLAY;
    localparam logic [1:0] ST_HOLD = HOLD;
    localparam logic [1:0] ST_HIGH = HIGH;

    localparam int PRE_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int HOLD_W = $clog2(HOLD_TICKS + 1);

    logic [1:0]         state;
    logic [1:0]         next_state;
    logic [SCORE_W-1:0] final_score;
    logic [SCORE_W-1:0] disp_src;
    logic [PRE_W-1:0]   presc;
    logic [HOLD_W-1:0]  hold_cnt;
    logic               tick;
    logic               hold_done;
    logic               game_end;
    logic [BCD_W-1:0]   tens_c;
    logic [BCD_W-1:0]   ones_c;

    // A food pickup in the same cycle as a crash changes nothing: the crash wins.
    logic unused_good;
    assign unused_good = goodColl;

    assign gameState = state;

    always_comb begin
        tick       = (state == ST_HOLD) && (presc == PRE_W'(TICK_DIV - 1));
        hold_done  = tick && (hold_cnt == HOLD_W'(HOLD_TICKS - 1));
        game_end   = badColl || (int'(currScore) >= MAX_SCORE);
        next_state = state;
        case (state)
            ST_IDLE: if (startBtn)  next_state = ST_PLAY;
            ST_PLAY: if (game_end)  next_state = ST_HOLD;
            ST_HOLD: if (hold_done) next_state = ST_HIGH;
            default: if (startBtn)  next_state = ST_PLAY;
        endcase
    end

    // Source follows the next state so the digits change together with gameState;
    // on the PLAY->HOLD edge the latch is not yet loaded, so take currScore directly.
    always_comb begin
        case (next_state)
            ST_PLAY: disp_src = currScore;
            ST_HOLD: disp_src = (state == ST_PLAY) ? currScore : final_score;
            default: disp_src = highScore;
        endcase
    end

    bin2bcd7 u_bcd (
        .value (disp_src),
        .tens  (tens_c),
        .ones  (ones_c)
    );

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state       <= ST_IDLE;
            final_score <= '0;
            presc       <= '0;
            hold_cnt    <= '0;
            runEn       <= 1'b0;
            tens        <= '0;
            ones        <= '0;
        end else begin
            state <= next_state;
            runEn <= (next_state == ST_PLAY);
            tens  <= tens_c;
            ones  <= ones_c;
            if (state == ST_PLAY && next_state == ST_HOLD)
                final_score <= currScore;
            // Counters idle at zero outside HOLD, so every entry starts a fresh hold.
            if (state != ST_HOLD) begin
                presc    <= '0;
                hold_cnt <= '0;
            end else if (tick) begin
                presc    <= '0;
                hold_cnt <= hold_cnt + HOLD_W'(1);
            end else begin
                presc    <= presc + PRE_W'(1);
            end
        end
    end

`ifdef SCORE_FLASH_EN
    localparam int BLINK_W = $clog2(BLINK_TICKS + 1);

    logic [BLINK_W-1:0] blink_cnt;

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            blink_cnt <= '0;
            blank     <= 1'b0;
        end else if (state != ST_HOLD || next_state != ST_HOLD) begin
            blink_cnt <= '0;
            blank     <= 1'b0;
        end else if (tick) begin
            if (blink_cnt == BLINK_W'(BLINK_TICKS - 1)) begin
                blink_cnt <= '0;
                blank     <= ~blank;
            end else begin
                blink_cnt <= blink_cnt + BLINK_W'(1);
            end
        end
    end
`else
    logic unused_blink_cfg;
    assign unused_blink_cfg = (BLINK_TICKS > 0);
    assign blank = 1'b0;
`endif

endmodule

// File: tb/tb_score_display_sequencer.sv
// Directed and randomized bench for score_display_sequencer against a cycle-count reference model.
module tb_score_display_sequencer;

    localparam int TD = 4;
    localparam int HT = 6;
    localparam int BT = 2;
    localparam int MS = 50;

    logic       clk;
    logic       nRst;
    logic       startBtn;
    logic       badColl;
    logic       goodColl;
    logic [6:0] currScore;
    logic [6:0] highScore;
    logic       runEn;
    logic [1:0] gameState;
    logic       blank;
    logic [3:0] tens;
    logic [3:0] ones;

    int tests_run = 0;
    int tests_failed = 0;

    // reference model: state number, latched final, cycles completed in HOLD, shown value
    int m_state;
    int m_final;
    int m_h;
    int m_disp;
    int m_blank;

    score_display_sequencer #(
        .TICK_DIV    (TD),
        .HOLD_TICKS  (HT),
        .BLINK_TICKS (BT),
        .MAX_SCORE   (MS)
    ) dut (
        .clk       (clk),
        .nRst      (nRst),
        .startBtn  (startBtn),
        .badColl   (badColl),
        .goodColl  (goodColl),
        .currScore (currScore),
        .highScore (highScore),
        .runEn     (runEn),
        .gameState (gameState),
        .blank     (blank),
        .tens      (tens),
        .ones      (ones)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int shown(input int v);
        return (v > 99) ? 99 : v;
    endfunction

    task automatic model_reset();
        m_state = 0;
        m_final = 0;
        m_h     = 0;
        m_disp  = 0;
        m_blank = 0;
    endtask

    task automatic model_step();
        int cs;
        int hs;
        cs = int'(currScore);
        hs = int'(highScore);
        case (m_state)
            1: begin
                if (badColl || cs >= MS) begin
                    m_state = 2;
                    m_final = cs;
                    m_h     = 0;
                end
                m_disp = cs;
            end
            2: begin
                m_h = m_h + 1;
                if (m_h == HT * TD) begin
                    m_state = 3;
                    m_disp  = hs;
                end else begin
                    m_disp = m_final;
                end
            end
            default: begin
                if (startBtn) begin
                    m_state = 1;
                    m_disp  = cs;
                end else begin
                    m_disp = hs;
                end
            end
        endcase
`ifdef SCORE_FLASH_EN
        m_blank = (m_state == 2 && ((m_h / (BT * TD)) % 2) == 1) ? 1 : 0;
`else
        m_blank = 0;
`endif
    endtask

    task automatic check_all(input string tag);
        check({tag, "_state"}, 8'(gameState), 8'(m_state));
        check({tag, "_runEn"}, 8'(runEn), 8'((m_state == 1) ? 1 : 0));
        check({tag, "_blank"}, 8'(blank), 8'(m_blank));
        check({tag, "_tens"}, 8'(tens), 8'(shown(m_disp) / 10));
        check({tag, "_ones"}, 8'(ones), 8'(shown(m_disp) % 10));
    endtask

    task automatic step(input string tag, input bit s, input bit b, input bit g,
                        input int cs, input int hs);
        startBtn  = s;
        badColl   = b;
        goodColl  = g;
        currScore = 7'(cs);
        highScore = 7'(hs);
        model_step();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        nRst      = 1'b0;
        startBtn  = 1'b0;
        badColl   = 1'b0;
        goodColl  = 1'b0;
        currScore = 7'd0;
        highScore = 7'd12;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all("reset");
        nRst = 1'b1;

        // 1. idle shows high score, start enters PLAY
        step("t1_idle", 0, 0, 0, 0, 12);
        check("t1_tens_lit", 8'(tens), 8'd1);
        check("t1_ones_lit", 8'(ones), 8'd2);
        step("t1_start", 1, 0, 0, 0, 12);
        check("t1_play_lit", 8'(gameState), 8'd1);
        check("t1_run_lit", 8'(runEn), 8'd1);

        // 2. live score display
        step("t2_s7", 0, 0, 0, 7, 12);
        step("t2_s8", 0, 0, 0, 8, 12);
        step("t2_s9", 0, 0, 0, 9, 12);
        check("t2_ones_lit", 8'(ones), 8'd9);

        // 3. crash, 24-cycle hold, then high score
        step("t3_crash", 0, 1, 0, 23, 12);
        check("t3_hold_lit", 8'(gameState), 8'd2);
        for (int i = 0; i < HT * TD; i++) step("t3_hold", 0, 0, 0, 0, 30);
        check("t3_high_lit", 8'(gameState), 8'd3);
        check("t3_tens_lit", 8'(tens), 8'd3);
        check("t3_ones_lit", 8'(ones), 8'd0);

        // 4. max score ends game; start ignored in HOLD
        step("t4_start", 1, 0, 0, 0, 30);
        step("t4_s49", 0, 0, 0, 49, 30);
        step("t4_s50", 0, 0, 0, 50, 30);
        check("t4_hold_lit", 8'(gameState), 8'd2);
        step("t4_btn", 1, 0, 0, 0, 30);
        check("t4_ignored_lit", 8'(gameState), 8'd2);
        check("t4_tens_lit", 8'(tens), 8'd5);
        for (int i = 0; i < HT * TD - 1; i++) step("t4_hold", 0, 0, 0, 0, 30);

        // 6a. simultaneous food and crash
        step("t6_start", 1, 0, 0, 8, 30);
        step("t6_both", 0, 1, 1, 9, 30);
        step("t6_after", 0, 0, 0, 10, 30);
        check("t6_final_lit", 8'(ones), 8'd9);
        step("t6_after2", 0, 0, 0, 10, 30);

        // 6b. asynchronous reset in the middle of HOLD
        #2;
        nRst = 1'b0;
        #1;
        model_reset();
        check("t6_rst_state", 8'(gameState), 8'd0);
        check("t6_rst_run", 8'(runEn), 8'd0);
        check("t6_rst_blank", 8'(blank), 8'd0);
        check("t6_rst_tens", 8'(tens), 8'd0);
        check("t6_rst_ones", 8'(ones), 8'd0);
        @(posedge clk);
        #1;
        nRst = 1'b1;

        // 6c. saturation
        step("t6_sat", 0, 0, 0, 0, 127);
        check("t6_sat_lit", 8'({tens, ones}), 8'h99);

        // randomized play
        for (int i = 0; i < 800; i++) begin
            step("rnd",
                 ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 3) == 0),
                 int'($urandom_range(0, 52)),
                 int'($urandom_range(0, 127)));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
